// File: rtl/aes_package.sv
// ---------------------------------------------------------------------------
// aes_package
// Shared constants and types for the AES engine TCDM responder.
//   TCDM_DW / TCDM_BW : data width in bits / byte lanes of one TCDM word
//   TCDM_ERR_DATA     : read data returned for an out-of-range read
//   tcdm_resp_cnt_t   : responder statistics (reads, writes, sticky error)
// ---------------------------------------------------------------------------
package aes_package;

  localparam int unsigned TCDM_DW = 32;
  localparam int unsigned TCDM_BW = 4;
  localparam logic [31:0] TCDM_ERR_DATA = 32'hDEAD_BEEF;

  typedef struct packed {
    logic [31:0] n_reads;
    logic [31:0] n_writes;
    logic        err;
  } tcdm_resp_cnt_t;

endpackage

// File: rtl/hwpe_stream_intf_tcdm.sv
// ---------------------------------------------------------------------------
// hwpe_stream_intf_tcdm
// One TCDM port: request side (req/add/wen/be/data) from the master,
// grant and response side (gnt/r_data/r_valid) from the slave.
//   wen = 1 means read, wen = 0 means write.
// ---------------------------------------------------------------------------
interface hwpe_stream_intf_tcdm;

  logic        req;
  logic        gnt;
  logic [31:0] add;
  logic        wen;
  logic [3:0]  be;
  logic [31:0] data;
  logic [31:0] r_data;
  logic        r_valid;

  modport master (
    output req, add, wen, be, data,
    input  gnt, r_data, r_valid
  );

  modport slave (
    input  req, add, wen, be, data,
    output gnt, r_data, r_valid
  );

endinterface

// File: rtl/aes_rr_arbiter.sv
// ---------------------------------------------------------------------------
// aes_rr_arbiter
// Round-robin arbiter: grants at most one requester per cycle, scanning from
// the priority pointer rr_q upwards (mod NP). After a grant the pointer moves
// to the port just after the winner; without a grant it holds.
//   clk_i, rst_ni : clock, asynchronous active-low reset
//   req_i         : request vector
//   en_i          : when 0 no grant is issued
//   clear_i       : synchronous return of the pointer to port 0
//   gnt_o         : one-hot grant vector (combinational)
//   idx_o         : index of the granted port (valid only with valid_o)
//   valid_o       : a grant is issued this cycle
// ---------------------------------------------------------------------------
module aes_rr_arbiter #(
  parameter  int unsigned NP = 4,
  localparam int unsigned IW = (NP > 1) ? $clog2(NP) : 1
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic [NP-1:0] req_i,
  input  logic          en_i,
  input  logic          clear_i,
  output logic [NP-1:0] gnt_o,
  output logic [IW-1:0] idx_o,
  output logic          valid_o
);

  logic [IW-1:0] rr_q;
  logic [IW:0]   cand;
  logic          any_req;

  // Scan offsets from the highest down to zero so that the requester closest
  // to rr_q is the last one written and therefore wins.
  always_comb begin
    cand    = '0;
    any_req = 1'b0;
    idx_o   = '0;
    for (int k = NP - 1; k >= 0; k--) begin
      cand = {1'b0, rr_q} + (IW+1)'(k);
      if (cand >= (IW+1)'(NP)) begin
        cand = cand - (IW+1)'(NP);
      end
      if (req_i[cand[IW-1:0]]) begin
        any_req = 1'b1;
        idx_o   = cand[IW-1:0];
      end
    end
    valid_o = any_req & en_i;
    gnt_o   = valid_o ? (NP'(1) << idx_o) : '0;
  end

  // Priority pointer: clear wins over the post-grant advance.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rr_q <= '0;
    end else if (clear_i) begin
      rr_q <= '0;
    end else if (valid_o) begin
      rr_q <= (idx_o == IW'(NP - 1)) ? '0 : idx_o + 1'b1;
    end
  end

endmodule

// File: rtl/aes_tcdm_responder.sv
// ---------------------------------------------------------------------------
// aes_tcdm_responder
// Single-bank TCDM slave memory serving NP master ports (AES streamer
// plaintext loads and ciphertext stores). One access per cycle, chosen
// round-robin; grant is combinational, the response (r_valid/r_data) comes
// exactly one cycle later on the granted port.
//   clk_i, rst_ni : clock, asynchronous active-low reset
//   clear_i       : synchronous clear of arbiter pointer, counters, err_o
//   stall_i       : suppresses grants while high
//   tcdm[NP]      : TCDM slave ports
//   n_reads_o     : granted reads since reset/clear
//   n_writes_o    : granted writes since reset/clear
//   err_o         : sticky flag, an out-of-range access was granted
// ---------------------------------------------------------------------------
module aes_tcdm_responder
  import aes_package::*;
#(
  parameter int unsigned NP        = 4,
  parameter int unsigned MEM_WORDS = 1024,
  parameter logic [31:0] BASE_ADDR = 32'h1C00_0000
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 clear_i,
  input  logic                 stall_i,
  hwpe_stream_intf_tcdm.slave  tcdm [NP-1:0],
  output logic [31:0]          n_reads_o,
  output logic [31:0]          n_writes_o,
  output logic                 err_o
);

  localparam int unsigned IW = (NP > 1) ? $clog2(NP) : 1;
  localparam int unsigned AW = $clog2(MEM_WORDS);

  // Flattened view of the port bundle
  logic [NP-1:0]        req_v;
  logic [NP-1:0]        wen_v;
  logic [31:0]          add_v  [NP];
  logic [TCDM_BW-1:0]   be_v   [NP];
  logic [TCDM_DW-1:0]   data_v [NP];

  // Arbitration
  logic                 arb_en;
  logic [NP-1:0]        arb_gnt;
  logic [IW-1:0]        arb_idx;
  logic                 arb_valid;

  // Selected request and its decode
  logic [31:0]          sel_add;
  logic                 sel_wen;
  logic [TCDM_BW-1:0]   sel_be;
  logic [TCDM_DW-1:0]   sel_data;
  logic [31:0]          offset;
  logic                 in_range;
  logic [AW-1:0]        word_idx;
  logic                 mem_we;
  logic [TCDM_DW-1:0]   resp_data;
  logic                 unused_byte_offset;

  // Storage and registered state
  logic [TCDM_DW-1:0]   mem       [MEM_WORDS];
  logic [NP-1:0]        r_valid_q;
  logic [TCDM_DW-1:0]   r_data_q  [NP];
  tcdm_resp_cnt_t       cnt_q;

  for (genvar p = 0; p < NP; p++) begin : g_port
    assign req_v[p]        = tcdm[p].req;
    assign wen_v[p]        = tcdm[p].wen;
    assign add_v[p]        = tcdm[p].add;
    assign be_v[p]         = tcdm[p].be;
    assign data_v[p]       = tcdm[p].data;
    assign tcdm[p].gnt     = arb_gnt[p];
    assign tcdm[p].r_valid = r_valid_q[p];
    assign tcdm[p].r_data  = r_data_q[p];
  end

  // rst_ni is folded in so that gnt drops immediately while reset is held,
  // which also keeps the un-reset memory from being written during reset.
  assign arb_en = rst_ni & ~stall_i & ~clear_i;

  aes_rr_arbiter #(
    .NP (NP)
  ) i_arbiter (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .req_i   (req_v),
    .en_i    (arb_en),
    .clear_i (clear_i),
    .gnt_o   (arb_gnt),
    .idx_o   (arb_idx),
    .valid_o (arb_valid)
  );

  assign sel_add  = add_v[arb_idx];
  assign sel_wen  = wen_v[arb_idx];
  assign sel_be   = be_v[arb_idx];
  assign sel_data = data_v[arb_idx];

  // The subtraction wraps for addresses below the base, so the lower-bound
  // test is done on the raw address and the upper bound on the offset.
  assign offset             = sel_add - BASE_ADDR;
  assign in_range           = (sel_add >= BASE_ADDR) && (offset[31:AW+2] == '0);
  assign word_idx           = offset[AW+1:2];
  assign unused_byte_offset = ^offset[1:0];

  assign mem_we    = arb_valid & ~sel_wen & in_range;
  assign resp_data = !sel_wen   ? '0
                   : in_range  ? mem[word_idx]
                   :             TCDM_ERR_DATA;

  // Memory array, byte-lane writes; deliberately not reset.
  always_ff @(posedge clk_i) begin
    if (mem_we) begin
      for (int b = 0; b < TCDM_BW; b++) begin
        if (sel_be[b]) begin
          mem[word_idx][8*b +: 8] <= sel_data[8*b +: 8];
        end
      end
    end
  end

  // Response stage: r_valid follows the grant by one cycle; r_data of a port
  // only changes when that port receives a response. Neither clear nor stall
  // touches this stage, so an already pipelined response is still delivered.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_valid_q <= '0;
      for (int p = 0; p < NP; p++) begin
        r_data_q[p] <= '0;
      end
    end else begin
      r_valid_q <= arb_gnt;
      if (arb_valid) begin
        r_data_q[arb_idx] <= resp_data;
      end
    end
  end

  // Access counters and sticky error; clear wins over any update.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else if (clear_i) begin
      cnt_q <= '0;
    end else if (arb_valid) begin
      if (sel_wen) begin
        cnt_q.n_reads <= cnt_q.n_reads + 32'd1;
      end else begin
        cnt_q.n_writes <= cnt_q.n_writes + 32'd1;
      end
      if (!in_range) begin
        cnt_q.err <= 1'b1;
      end
    end
  end

  assign n_reads_o  = cnt_q.n_reads;
  assign n_writes_o = cnt_q.n_writes;
  assign err_o      = cnt_q.err;

endmodule

// File: tb/tb_aes_tcdm_responder.sv
// ---------------------------------------------------------------------------
// tb_aes_tcdm_responder
// Self-checking bench: a table of per-cycle vectors (requests, expected
// grant) plus a hand-written reset-mid-burst sequence. Expected responses
// are computed from a reference memory model and queued at grant time, then
// popped and compared when the response cycle comes around.
// ---------------------------------------------------------------------------
module tb_aes_tcdm_responder;
  import aes_package::*;

  localparam int          NP        = 4;
  localparam int          MEM_WORDS = 1024;
  localparam logic [31:0] BASE      = 32'h1C00_0000;
  localparam logic [31:0] OOR_ADDR  = BASE + 32'(4 * MEM_WORDS);

  typedef struct {
    string       name;
    logic [3:0]  req;
    logic        wen;
    logic [31:0] addr;
    logic [3:0]  be;
    logic [31:0] data;
    logic        stall;
    logic        clear;
    logic [3:0]  exp_gnt;
  } vec_t;

  typedef struct {
    int          port;
    logic [31:0] data;
  } resp_t;

  logic          clk_i = 1'b0;
  logic          rst_ni;
  logic          clear_i;
  logic          stall_i;
  logic [31:0]   n_reads_o;
  logic [31:0]   n_writes_o;
  logic          err_o;

  logic [NP-1:0] req_drv;
  logic          wen_drv;
  logic [31:0]   add_drv;
  logic [3:0]    be_drv;
  logic [31:0]   data_drv;
  logic [NP-1:0] gnt_mon;
  logic [NP-1:0] r_valid_mon;
  logic [31:0]   r_data_mon [NP];

  int            n_tests = 0;
  int            n_fail  = 0;
  vec_t          vecs [$];
  resp_t         exp_q [$];
  logic [31:0]   model_mem [int];
  logic [31:0]   model_rdata [NP];
  logic [31:0]   model_reads;
  logic [31:0]   model_writes;
  logic          model_err;

  hwpe_stream_intf_tcdm tcdm_if [NP-1:0] ();

  for (genvar i = 0; i < NP; i++) begin : g_if
    assign tcdm_if[i].req  = req_drv[i];
    assign tcdm_if[i].wen  = wen_drv;
    assign tcdm_if[i].add  = add_drv;
    assign tcdm_if[i].be   = be_drv;
    assign tcdm_if[i].data = data_drv;
    assign gnt_mon[i]      = tcdm_if[i].gnt;
    assign r_valid_mon[i]  = tcdm_if[i].r_valid;
    assign r_data_mon[i]   = tcdm_if[i].r_data;
  end

  aes_tcdm_responder #(
    .NP        (NP),
    .MEM_WORDS (MEM_WORDS),
    .BASE_ADDR (BASE)
  ) dut (
    .clk_i      (clk_i),
    .rst_ni     (rst_ni),
    .clear_i    (clear_i),
    .stall_i    (stall_i),
    .tcdm       (tcdm_if),
    .n_reads_o  (n_reads_o),
    .n_writes_o (n_writes_o),
    .err_o      (err_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic add_vec(input string name, input logic [3:0] req, input logic wen,
                         input logic [31:0] addr, input logic [3:0] be, input logic [31:0] data,
                         input logic stall, input logic clear, input logic [3:0] exp_gnt);
    vec_t v;
    v.name = name; v.req = req; v.wen = wen; v.addr = addr; v.be = be;
    v.data = data; v.stall = stall; v.clear = clear; v.exp_gnt = exp_gnt;
    vecs.push_back(v);
  endtask

  task automatic model_reset();
    exp_q.delete();
    model_reads  = '0;
    model_writes = '0;
    model_err    = 1'b0;
    for (int p = 0; p < NP; p++) model_rdata[p] = '0;
  endtask

  task automatic check_counters(input string name);
    check_output({name, ":n_reads"}, n_reads_o, model_reads);
    check_output({name, ":n_writes"}, n_writes_o, model_writes);
    check_output({name, ":err"}, 32'(err_o), 32'(model_err));
  endtask

  // Starts on a falling edge, ends on the next falling edge.
  task automatic apply_stimulus(input string name, input logic [3:0] req, input logic wen,
                                input logic [31:0] addr, input logic [3:0] be, input logic [31:0] data,
                                input logic stall, input logic clear, input logic [3:0] exp_gnt);
    resp_t       e;
    int          gp;
    logic        in_rng;
    int          word;
    logic [31:0] nw;
    req_drv  = req;
    wen_drv  = wen;
    add_drv  = addr;
    be_drv   = be;
    data_drv = data;
    stall_i  = stall;
    clear_i  = clear;
    #1;
    // Response owed from the previous cycle's grant
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check_output({name, ":r_valid"}, 32'(r_valid_mon), 32'(1) << e.port);
      model_rdata[e.port] = e.data;
    end else begin
      check_output({name, ":r_valid_idle"}, 32'(r_valid_mon), 32'd0);
    end
    for (int p = 0; p < NP; p++) begin
      check_output($sformatf("%s:r_data%0d", name, p), r_data_mon[p], model_rdata[p]);
    end
    check_output({name, ":gnt"}, 32'(gnt_mon), 32'(exp_gnt));
    // Model the access that the expected grant performs
    gp = -1;
    for (int p = 0; p < NP; p++) if (exp_gnt[p]) gp = p;
    if (gp >= 0) begin
      in_rng = (addr >= BASE) && (addr < OOR_ADDR);
      word   = int'((addr - BASE) >> 2);
      e.port = gp;
      if (wen) begin
        model_reads++;
        e.data = in_rng ? model_mem[word] : 32'hDEAD_BEEF;
      end else begin
        model_writes++;
        e.data = 32'h0;
        if (in_rng) begin
          nw = model_mem.exists(word) ? model_mem[word] : 32'h0;
          for (int b = 0; b < 4; b++) if (be[b]) nw[8*b +: 8] = data[8*b +: 8];
          model_mem[word] = nw;
        end
      end
      if (!in_rng) model_err = 1'b1;
      exp_q.push_back(e);
    end
    if (clear) begin
      model_reads  = '0;
      model_writes = '0;
      model_err    = 1'b0;
    end
    @(posedge clk_i);
    #1;
    check_counters(name);
    @(negedge clk_i);
  endtask

  initial begin
    rst_ni   = 1'b0;
    clear_i  = 1'b0;
    stall_i  = 1'b0;
    req_drv  = '0;
    wen_drv  = 1'b0;
    add_drv  = '0;
    be_drv   = '0;
    data_drv = '0;
    model_reset();

    //       name            req      wen   addr             be       data           stall clear exp_gnt
    add_vec("wr_single",    4'b0001, 1'b0, BASE + 32'h10,   4'hF,    32'hA5A5_1234, 1'b0, 1'b0, 4'b0001);
    add_vec("rd_single",    4'b0001, 1'b1, BASE + 32'h10,   4'hF,    32'h0,         1'b0, 1'b0, 4'b0001);
    add_vec("idle0",        4'b0000, 1'b1, BASE,            4'hF,    32'h0,         1'b0, 1'b0, 4'b0000);
    add_vec("be_preload",   4'b0010, 1'b0, BASE + 32'h20,   4'hF,    32'h1122_3344, 1'b0, 1'b0, 4'b0010);
    add_vec("be_write",     4'b0010, 1'b0, BASE + 32'h20,   4'b0101, 32'hFFFF_FFFF, 1'b0, 1'b0, 4'b0010);
    add_vec("be_read",      4'b0010, 1'b1, BASE + 32'h20,   4'hF,    32'h0,         1'b0, 1'b0, 4'b0010);
    add_vec("clear_rr",     4'b0000, 1'b1, BASE,            4'hF,    32'h0,         1'b0, 1'b1, 4'b0000);
    for (int c = 0; c < 8; c++) begin
      add_vec($sformatf("rr%0d", c), 4'b1111, 1'b1, BASE + 32'h10, 4'hF, 32'h0, 1'b0, 1'b0, 4'(1 << (c % 4)));
    end
    for (int c = 0; c < 3; c++) begin
      add_vec($sformatf("stall%0d", c), 4'b0100, 1'b1, BASE + 32'h10, 4'hF, 32'h0, 1'b1, 1'b0, 4'b0000);
    end
    add_vec("stall_release", 4'b0100, 1'b1, BASE + 32'h10,  4'hF,    32'h0,         1'b0, 1'b0, 4'b0100);
    add_vec("idle1",        4'b0000, 1'b1, BASE,            4'hF,    32'h0,         1'b0, 1'b0, 4'b0000);
    add_vec("oor_read",     4'b1000, 1'b1, OOR_ADDR,        4'hF,    32'h0,         1'b0, 1'b0, 4'b1000);
    add_vec("err_sticky",   4'b0000, 1'b1, BASE,            4'hF,    32'h0,         1'b0, 1'b0, 4'b0000);
    add_vec("oor_wr_low",   4'b0001, 1'b0, BASE - 32'h4,    4'hF,    32'h1234_5678, 1'b0, 1'b0, 4'b0001);
    add_vec("clear_err",    4'b0000, 1'b1, BASE,            4'hF,    32'h0,         1'b0, 1'b1, 4'b0000);
    add_vec("clear_no_gnt", 4'b0001, 1'b1, BASE + 32'h10,   4'hF,    32'h0,         1'b0, 1'b1, 4'b0000);
    add_vec("reread",       4'b0001, 1'b1, BASE + 32'h10,   4'hF,    32'h0,         1'b0, 1'b0, 4'b0001);
    add_vec("b2b_write",    4'b0100, 1'b0, BASE + 32'h30,   4'hF,    32'hCAFE_F00D, 1'b0, 1'b0, 4'b0100);
    add_vec("b2b_read",     4'b1000, 1'b1, BASE + 32'h30,   4'hF,    32'h0,         1'b0, 1'b0, 4'b1000);
    add_vec("last_wr",      4'b0001, 1'b0, OOR_ADDR - 32'h4, 4'hF,   32'h0BAD_C0DE, 1'b0, 1'b0, 4'b0001);
    add_vec("last_rd",      4'b0010, 1'b1, OOR_ADDR - 32'h4, 4'hF,   32'h0,         1'b0, 1'b0, 4'b0010);
    add_vec("idle2",        4'b0000, 1'b1, BASE,            4'hF,    32'h0,         1'b0, 1'b0, 4'b0000);

    // Reset state
    repeat (2) @(negedge clk_i);
    #1;
    check_output("reset:gnt", 32'(gnt_mon), 32'd0);
    check_output("reset:r_valid", 32'(r_valid_mon), 32'd0);
    for (int p = 0; p < NP; p++) check_output($sformatf("reset:r_data%0d", p), r_data_mon[p], 32'd0);
    check_counters("reset");
    @(negedge clk_i);
    rst_ni = 1'b1;

    for (int i = 0; i < vecs.size(); i++) begin
      apply_stimulus(vecs[i].name, vecs[i].req, vecs[i].wen, vecs[i].addr, vecs[i].be,
                     vecs[i].data, vecs[i].stall, vecs[i].clear, vecs[i].exp_gnt);
    end

    // Reset asserted mid-burst with ports 0 and 1 requesting
    apply_stimulus("rst_pre", 4'b0011, 1'b1, BASE + 32'h10, 4'hF, 32'h0, 1'b0, 1'b0, 4'b0001);
    rst_ni = 1'b0;
    #1;
    check_output("rst_mid:gnt", 32'(gnt_mon), 32'd0);
    check_output("rst_mid:r_valid", 32'(r_valid_mon), 32'd0);
    check_output("rst_mid:r_data0", r_data_mon[0], 32'd0);
    model_reset();
    check_counters("rst_mid");
    @(negedge clk_i);
    rst_ni = 1'b1;
    apply_stimulus("rst_restart", 4'b0011, 1'b1, BASE + 32'h10, 4'hF, 32'h0, 1'b0, 1'b0, 4'b0001);
    apply_stimulus("rst_next",    4'b0011, 1'b1, BASE + 32'h10, 4'hF, 32'h0, 1'b0, 1'b0, 4'b0010);
    apply_stimulus("rst_mem_kept", 4'b0001, 1'b1, BASE + 32'h10, 4'hF, 32'h0, 1'b0, 1'b0, 4'b0001);
    apply_stimulus("flush",       4'b0000, 1'b1, BASE,          4'hF, 32'h0, 1'b0, 1'b0, 4'b0000);
    check_output("final:rdata0", r_data_mon[0], 32'hA5A5_1234);
    check_output("final:queue_empty", 32'(exp_q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/aes_tcdm_responder.md
Name: aes_tcdm_responder

Overview:
- Single-bank TCDM slave memory that answers the AES engine streamer's TCDM master ports (plaintext load, ciphertext store).
- Sits in the HWPE testbench/cluster-model as the memory end of the hwpe_stream_intf_tcdm protocol.
- Provides round-robin arbitration across ports, one access per cycle, one-cycle read latency, byte-enable writes, programmable stall injection and access counters.

Parameters:
- NP, 4, number of TCDM slave ports (≥1).
- MEM_WORDS, 1024, memory depth in 32-bit words (power of 2).
- BASE_ADDR, 32'h1C00_0000, byte address of word 0.

Ports:
- clk_i  input  1  clock.
- rst_ni  input  1  asynchronous active-low reset.
- clear_i  input  1  synchronous clear of arbiter pointer, counters and error flag; memory contents kept.
- stall_i  input  1  when 1, no grant is issued this cycle.
- tcdm  slave modport  NP x hwpe_stream_intf_tcdm  per port: req, gnt, add[31:0], wen (1 = read, 0 = write), be[3:0], data[31:0], r_data[31:0], r_valid.
- n_reads_o  output  32  granted reads since reset/clear.
- n_writes_o  output  32  granted writes since reset/clear.
- err_o  output  1  sticky: an out-of-range access was granted.

Behaviour:
- Reset: all gnt=0, r_valid=0, r_data=0, counters=0, err_o=0, rr_q=0. Memory is not reset.
- Grant is combinational in the same cycle as req.
  - At most one port is granted per cycle.
  - No grant while stall_i=1 or clear_i=1.
- Arbitration: pick the first requesting port scanning rr_q, rr_q+1, … (mod NP). On a grant, rr_q <= (granted index + 1) mod NP. With no grant, rr_q holds.
- Address decode: word index = (add − BASE_ADDR) >> 2. The access is in range iff BASE_ADDR ≤ add < BASE_ADDR + 4*MEM_WORDS. add[1:0] is ignored.
- Granted write, in range: at the next rising edge, each byte b with be[b]=1 is written from data[8b+7:8b]. Bytes with be[b]=0 are unchanged.
- Granted write, out of range: memory unchanged; err_o <= 1.
- Granted read, in range: r_data = memory word on the cycle after the grant.
- Granted read, out of range: r_data = 32'hDEAD_BEEF; err_o <= 1.
- Response timing:
  - r_valid=1 on exactly the granted port, exactly one cycle after the grant, for both reads and writes.
  - For writes, r_data = 0.
  - Non-granted ports have r_valid=0. r_data holds its last value when r_valid=0.
- Back-to-back: a new grant is allowed every cycle. A read granted in the cycle after a write to the same word returns the written data (write commits at that edge).
- Counters: increment by 1 per granted read or write and wrap at 2^32. clear_i zeroes them, zeroes rr_q and clears err_o; clear_i has priority over increments.
- Response pipeline on clear/stall: a response already pipelined (grant in the previous cycle) is still delivered on the cycle clear_i or stall_i is asserted.
- Reset mid-operation: the pending r_valid is dropped; memory contents after an interrupted cycle are undefined only for the word being written at the reset edge.
- Requester protocol: a requester must hold req/add/wen/be/data stable until gnt. The responder does not check this.

Decomposition:
- Add to aes_package:
  - constants TCDM_DW=32, TCDM_BW=4, TCDM_ERR_DATA=32'hDEAD_BEEF;
  - typedef tcdm_resp_cnt_t (struct: n_reads, n_writes, err).
- One sub-module: aes_rr_arbiter, parameter NP.
  - Inputs: req_i[NP], en_i, clear_i.
  - Outputs: gnt_o[NP] (one-hot), idx_o, valid_o.
  - Holds rr_q internally.
- Memory array, response register and counters stay in aes_tcdm_responder.

Test Plan:
- Single port write then read: write add=BASE+0x10, data=32'hA5A5_1234, be=4'hF; next cycle read the same address → gnt in the same cycle; r_valid one cycle later; r_data=32'hA5A5_1234; n_writes=1, n_reads=1.
- Byte enables: word preloaded 32'h1122_3344; write data=32'hFFFF_FFFF, be=4'b0101; read back → 32'h11FF_33FF.
- Round robin: ports 0–3 all hold req continuously → grant order 0,1,2,3,0,…; exactly one r_valid per cycle on the port granted the previous cycle; after 8 cycles n_reads=8.
- Stall: stall_i=1 for 3 cycles with port 2 requesting → gnt=0 for 3 cycles; grant in the cycle stall_i falls; r_valid on port 2 the following cycle.
- Out of range: read add=BASE+4*MEM_WORDS → r_data=32'hDEAD_BEEF, err_o=1 and stays 1; clear_i pulse → err_o=0, counters=0, memory content preserved (re-read of the first test's word still gives 32'hA5A5_1234).
- Reset mid-burst: assert rst_ni=0 while ports 0 and 1 request → all gnt and r_valid 0 immediately; counters 0; after release, arbitration restarts at port 0.
